// File: rtl/merge_refill_scheduler.sv
// Refill scheduler for the leaf input FIFOs of a merge tree. Each leaf has a
// credit counter for its free FIFO space. One request channel is granted
// round-robin to leaves that can take a full burst. The number of bursts in
// flight is capped. The run ends when every leaf is terminated and all
// bursts have returned.
`timescale 1ns/1ps
module merge_refill_scheduler #(
    parameter int NUM_LEAVES      = 16,
    parameter int LEAF_W          = 4,
    parameter int FIFO_DEPTH      = 16,
    parameter int CNT_W           = 5,
    parameter int BURST_LEN       = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NUM_LEAVES-1:0] i_leaf_deq,
    input  logic [NUM_LEAVES-1:0] i_leaf_last,
    output logic                  o_req_valid,
    output logic [LEAF_W-1:0]     o_req_leaf,
    input  logic                  i_req_ready,
    input  logic                  i_rsp_done,
    output logic                  o_busy,
    output logic                  o_all_done,
    output logic                  o_err
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        credit [NUM_LEAVES];
    logic [OUT_W-1:0]        outstanding;
    logic [LEAF_W-1:0]       rr_ptr;
    logic [NUM_LEAVES-1:0]   done_mask;
    logic [NUM_LEAVES-1:0]   eligible;
    logic [NUM_LEAVES-1:0]   grant_hit;
    logic                    credit_ovf;
    logic                    rsp_err;
    logic                    win_found;
    logic [LEAF_W-1:0]       win_leaf;
    logic                    start_run;
    logic                    accept;
    logic                    slot_free;

    // A deq on a full-credit leaf is an error. The count clamps at the FIFO depth.
    function automatic logic [CNT_W-1:0] sat_credit(input logic [CNT_W-1:0] cur,
                                                    input logic             add,
                                                    input logic             sub);
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} + (CNT_W+1)'(add);
        if (sub)
            sum = sum - (CNT_W+1)'(BURST_LEN);
        if (sum > (CNT_W+1)'(FIFO_DEPTH))
            sum = (CNT_W+1)'(FIFO_DEPTH);
        return sum[CNT_W-1:0];
    endfunction

    assign start_run = (state == S_IDLE) && i_start;
    assign accept    = o_req_valid && i_req_ready;
    assign slot_free = outstanding < OUT_W'(MAX_OUTSTANDING);
    assign rsp_err   = i_rsp_done && !accept && (outstanding == '0);

    // Per-leaf eligibility, accepted-grant decode and credit overflow detect.
    always_comb begin
        eligible   = '0;
        grant_hit  = '0;
        credit_ovf = 1'b0;
        for (int i = 0; i < NUM_LEAVES; i++) begin
            eligible[i]  = (credit[i] >= CNT_W'(BURST_LEN)) && !done_mask[i] && slot_free;
            grant_hit[i] = accept && (o_req_leaf == LEAF_W'(i));
            if (i_leaf_deq[i] && !grant_hit[i] && (credit[i] == CNT_W'(FIFO_DEPTH)))
                credit_ovf = 1'b1;
        end
    end

    // Round-robin pick: first eligible leaf at or after rr_ptr, wrapping.
    always_comb begin
        logic [LEAF_W-1:0] idx;
        idx       = '0;
        win_found = 1'b0;
        win_leaf  = '0;
        for (int k = 0; k < NUM_LEAVES; k++) begin
            idx = rr_ptr + LEAF_W'(k);
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_leaf  = idx;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state and status outputs.
    always_comb begin
        state_nxt  = state;
        o_busy     = 1'b0;
        o_all_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start)
                    state_nxt = S_ARB;
            end
            S_ARB: begin
                o_busy = 1'b1;
                if (&done_mask)
                    state_nxt = S_DRAIN;
                else if (win_found)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                o_busy = 1'b1;
                if (accept)
                    state_nxt = S_ARB;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (outstanding == '0)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                o_all_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered request. It is held stable until the channel accepts it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_req_valid <= 1'b0;
            o_req_leaf  <= '0;
        end else if ((state == S_ARB) && (state_nxt == S_ISSUE)) begin
            o_req_valid <= 1'b1;
            o_req_leaf  <= win_leaf;
        end else if (accept) begin
            o_req_valid <= 1'b0;
        end
    end

    // Credit counters. Grants consume a burst, deqs return one entry each.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_LEAVES; i++)
                credit[i] <= CNT_W'(FIFO_DEPTH);
        end else begin
            for (int i = 0; i < NUM_LEAVES; i++) begin
                if (start_run)
                    credit[i] <= CNT_W'(FIFO_DEPTH);
                else
                    credit[i] <= sat_credit(credit[i], i_leaf_deq[i], grant_hit[i]);
            end
        end
    end

    // In-flight burst count, round-robin pointer and terminated-leaf mask.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            outstanding <= '0;
            rr_ptr      <= '0;
            done_mask   <= '0;
        end else begin
            case ({accept, i_rsp_done})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
            if (accept)
                rr_ptr <= o_req_leaf + LEAF_W'(1);
            if (start_run)
                done_mask <= '0;
            else if (state != S_IDLE)
                done_mask <= done_mask | i_leaf_last;
        end
    end

    // Sticky protocol error. It is cleared by reset or by starting a new run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_err <= 1'b0;
        else if (start_run)
            o_err <= 1'b0;
        else if (credit_ovf || rsp_err)
            o_err <= 1'b1;
    end

endmodule
